direction_pacer: RTL and testbench

- Front end of the cursor path: conditions the four raw push-buttons into single-cycle, rate-limited direction strobes.
- Output feeds movement_control's `directions` input, so each strobe moves the cursor exactly one pixel.
- Provides 2-flop synchronisation, per-key debounce, opposing-key cancellation, and keyboard-style auto-repeat: initial step, hold delay, then periodic steps.

---
 rtl/dir_pkg.sv | 29 ++
 rtl/key_debouncer.sv | 31 +++
 rtl/direction_pacer.sv | 121 ++++++++++++
 tb/tb_direction_pacer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// Shared definitions for the cursor direction path: bit indices, direction
// vector type, pacer FSM encoding and the opposing-key resolve helper.
package dir_pkg;

   localparam int DIR_LEFT  = 3;
   localparam int DIR_UP    = 2;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_DOWN  = 0;

   typedef logic [3:0] dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   // Opposing keys cancel on their own axis only.
   function automatic dir_t resolve(input dir_t f);
      dir_t a;
      a            = '0;
      a[DIR_LEFT]  = f[DIR_LEFT]  & ~f[DIR_RIGHT];
      a[DIR_RIGHT] = f[DIR_RIGHT] & ~f[DIR_LEFT];
      a[DIR_UP]    = f[DIR_UP]    & ~f[DIR_DOWN];
      a[DIR_DOWN]  = f[DIR_DOWN]  & ~f[DIR_UP];
      return a;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: the accepted level follows the synchronised input only
// after DEBOUNCE_CYCLES consecutive differing samples.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (raw == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= raw;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/direction_pacer.sv
// Push-button front end: sync, debounce, opposing-key cancel and auto-repeat
// into one-cycle direction strobes. Define DIR_PACER_DIAG_EN for diagonal steps.
module direction_pacer
   import dir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keys_n,
   output dir_t       directions,
   output logic       held
);

   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(TMAX);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   logic [3:0] sync_p0, sync_p1;
   dir_t       raw_p1, flt_p2, res_p2, act_p2;

   // Stage 0/1: two-flop synchroniser, released (high) out of reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '1;
         sync_p1 <= '1;
      end else begin
         sync_p0 <= keys_n;
         sync_p1 <= sync_p0;
      end
   end

   assign raw_p1 = ~sync_p1;

   // Stage 2: per-key debounce
   for (genvar i = 0; i < 4; i++) begin : g_deb
      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock (clock),
         .reset (reset),
         .raw   (raw_p1[i]),
         .stable(flt_p2[i])
      );
   end

   assign res_p2 = resolve(flt_p2);

`ifdef DIR_PACER_DIAG_EN
   assign act_p2 = res_p2;
`else
   // Horizontal wins when both axes are active.
   always_comb begin
      act_p2 = res_p2;
      if (res_p2[DIR_LEFT] | res_p2[DIR_RIGHT]) begin
         act_p2[DIR_UP]   = 1'b0;
         act_p2[DIR_DOWN] = 1'b0;
      end
   end
`endif

   state_t        state, state_n;
   dir_t          last, last_n, dir_n;
   logic [TW-1:0] tcnt, tcnt_n;

   // Stage 3: pacing FSM and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last       <= '0;
         tcnt       <= '0;
         directions <= '0;
         held       <= 1'b0;
      end else begin
         state      <= state_n;
         last       <= last_n;
         tcnt       <= tcnt_n;
         directions <= dir_n;
         held       <= |act_p2;
      end
   end

   always_comb begin
      state_n = state;
      last_n  = last;
      tcnt_n  = tcnt;
      dir_n   = '0;
      case (state)
         IDLE: begin
            if (act_p2 != '0) begin
               dir_n   = act_p2;
               last_n  = act_p2;
               tcnt_n  = '0;
               state_n = DELAY;
            end
         end
         DELAY, REPEAT: begin
            // Release beats a change, and a change beats the terminal count.
            if (act_p2 == '0) begin
               state_n = IDLE;
            end else if (act_p2 != last) begin
               dir_n   = act_p2;
               last_n  = act_p2;
               tcnt_n  = '0;
               state_n = DELAY;
            end else if (tcnt == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
               dir_n   = last;
               tcnt_n  = '0;
               state_n = REPEAT;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_direction_pacer.sv
// Directed bench for direction_pacer with a per-cycle behavioural model
// (press-segment timing) plus hand-computed strobe expectations.
module tb_direction_pacer;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] keys_n = 4'b1111;
   logic [3:0] directions;
   logic       held;

   direction_pacer #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .keys_n    (keys_n),
      .directions(directions),
      .held      (held)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: synchroniser history, accepted keys, mismatch run lengths,
   // and the current press segment (value and cycles since it began).
   logic [3:0] m_s0 = 4'b1111, m_s1 = 4'b1111, m_f = 4'b0000, m_a, m_raw;
   int         m_run [4] = '{0, 0, 0, 0};
   bit         m_seg = 1'b0;
   logic [3:0] m_seg_val = 4'b0000;
   int         m_age = 0;
   logic [3:0] m_dir = 4'b0000;
   logic       m_held = 1'b0;

   function automatic logic [3:0] m_resolve(input logic [3:0] f);
      logic [3:0] a;
      a = 4'b0000;
      if (f[3] != f[1]) a = a | (f[3] ? 4'b1000 : 4'b0010);
      if (f[2] != f[0]) a = a | (f[2] ? 4'b0100 : 4'b0001);
`ifndef DIR_PACER_DIAG_EN
      if ((a & 4'b1010) != 4'b0000) a = a & 4'b1010;
`endif
      return a;
   endfunction

   function automatic bit m_due(input int age);
      return (age == 0) || (age == RD) || ((age > RD) && (((age - RD) % RP) == 0));
   endfunction

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_s0 = 4'b1111; m_s1 = 4'b1111; m_f = 4'b0000;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_seg = 1'b0; m_dir = 4'b0000; m_held = 1'b0;
         end else begin
            m_a = m_resolve(m_f);
            if (m_a == 4'b0000) begin
               m_seg = 1'b0;
               m_dir = 4'b0000;
            end else begin
               if (!m_seg || m_a != m_seg_val) begin
                  m_seg = 1'b1; m_seg_val = m_a; m_age = 0;
               end else begin
                  m_age++;
               end
               m_dir = m_due(m_age) ? m_a : 4'b0000;
            end
            m_held = |m_a;
            m_raw = ~m_s1;
            for (int i = 0; i < 4; i++) begin
               if (m_raw[i] != m_f[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DB) begin
                     m_f[i] = m_raw[i];
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_s1 = m_s0;
            m_s0 = keys_n;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         chk("model_dir", directions, m_dir);
         chk("model_held", {3'b000, held}, {3'b000, m_held});
      end
   end

   int         nstrobe;
   logic [3:0] first;

   task automatic step();
      @(negedge clock);
      if (directions != 4'b0000) begin
         if (nstrobe == 0) first = directions;
         nstrobe++;
      end
   endtask

   initial begin
      // reset with keys released
      repeat (3) @(negedge clock);
      chk("reset_dir", directions, 4'b0000);
      chk("reset_held", {3'b000, held}, 4'b0000);
      reset = 1'b0;
      nstrobe = 0;
      repeat (10) step();
      chk("post_reset_quiet", 4'(nstrobe), 4'd0);

      // left held: strobes at 7, 27, 32, 37 ...
      keys_n = 4'b0111;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (i == 7 || i == 27 || i == 32 || i == 37 || i == 57)
            chk("left_strobe", directions, 4'b1000);
         else if (i == 6 || i == 8 || i == 26 || i == 28 || i == 31 || i == 33)
            chk("left_gap", directions, 4'b0000);
      end
      keys_n = 4'b1111;
      repeat (15) @(negedge clock);

      // right key chatter then steady press
      nstrobe = 0; first = 4'b0000;
      for (int c = 0; c < 12; c++) begin
         keys_n = (((c / 2) % 2) == 0) ? 4'b1101 : 4'b1111;
         step();
      end
      keys_n = 4'b1101;
      repeat (14) step();
      chk("chatter_count", 4'(nstrobe), 4'd1);
      chk("chatter_value", first, 4'b0010);
      keys_n = 4'b1111;
      repeat (15) @(negedge clock);

      // left and right cancel
      nstrobe = 0;
      keys_n = 4'b0101;
      repeat (30) step();
      chk("cancel_count", 4'(nstrobe), 4'd0);
      chk("cancel_held", {3'b000, held}, 4'b0000);
      keys_n = 4'b1111;
      repeat (15) @(negedge clock);

      // left and up together
      nstrobe = 0; first = 4'b0000;
      keys_n = 4'b0011;
      repeat (10) step();
      chk("axis_count", 4'(nstrobe), 4'd1);
`ifdef DIR_PACER_DIAG_EN
      chk("axis_value", first, 4'b1100);
`else
      chk("axis_value", first, 4'b1000);
`endif
      keys_n = 4'b1111;
      repeat (15) @(negedge clock);

      // down held, switched to up so the change lands on a repeat terminal count
      keys_n = 4'b1110;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (i == 7 || i == 27 || i == 32) chk("down_strobe", directions, 4'b0001);
         if (i == 37 || i == 57) chk("change_strobe", directions, 4'b0100);
         if (i == 38 || i == 42 || i == 56) chk("change_gap", directions, 4'b0000);
         if (i == 30) keys_n = 4'b1011;
      end
      reset = 1'b1;
      #1;
      chk("midhold_reset_dir", directions, 4'b0000);
      chk("midhold_reset_held", {3'b000, held}, 4'b0000);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (i == 7) chk("rearm_strobe", directions, 4'b0100);
         else chk("rearm_quiet", directions, 4'b0000);
      end
      keys_n = 4'b1111;
      repeat (15) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
